// File: rtl/median_window_gen.sv
// rtl/median_window_gen.sv - 3x3 pixel neighbourhood generator with two line buffers for a median sorter
module median_window_gen #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hsync,
    input  logic                  vsync,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     pix_in,
    output logic [9*DATA_W-1:0]   win_out,
    output logic                  win_valid
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] line1 [DEPTH];
    logic [DATA_W-1:0] line2 [DEPTH];
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    logic [DATA_W-1:0] pix_d;
    logic [ADDR_W-1:0] addr_d;
    logic              pix_vld_d;

    logic [1:0]        col_cnt;
    logic [1:0]        col_inc;
    logic [1:0]        row_cnt;
    logic              hsync_q;
    logic              line_wr;
    logic              line_end;
    logic [9*DATA_W-1:0] win_next;

    // Line RAMs: registered read, write one cycle behind the read of the same column
    always_ff @(posedge clk) begin
        rd1 <= line1[addr];
        if (pix_vld_d) begin
            line1[addr_d] <= pix_d;
        end
    end

    always_ff @(posedge clk) begin
        rd2 <= line2[addr];
        if (pix_vld_d) begin
            line2[addr_d] <= rd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_d     <= '0;
            addr_d    <= '0;
            pix_vld_d <= 1'b0;
        end else begin
            pix_d     <= pix_in;
            addr_d    <= addr;
            pix_vld_d <= ~hsync;
        end
    end

    assign col_inc  = (col_cnt == 2'd3) ? 2'd3 : 2'(col_cnt + 2'd1);
    assign line_end = hsync & ~hsync_q;

    // Shift every row one column left; column 2 takes {line2, line1, current pixel}
    always_comb begin
        win_next = win_out;
        for (int r = 0; r < 3; r++) begin
            win_next[DATA_W*(3*r)   +: DATA_W] = win_out[DATA_W*(3*r+1) +: DATA_W];
            win_next[DATA_W*(3*r+1) +: DATA_W] = win_out[DATA_W*(3*r+2) +: DATA_W];
        end
        win_next[DATA_W*2 +: DATA_W] = rd2;
        win_next[DATA_W*5 +: DATA_W] = rd1;
        win_next[DATA_W*8 +: DATA_W] = pix_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_out   <= '0;
            win_valid <= 1'b0;
            col_cnt   <= 2'd0;
        end else begin
            win_valid <= pix_vld_d && (row_cnt == 2'd2) && (col_inc == 2'd3);
            if (pix_vld_d) begin
                win_out <= win_next;
                col_cnt <= col_inc;
            end else begin
                col_cnt <= 2'd0;
            end
        end
    end

    // The last pixel of a line is still in stage 1 when hsync rises, so it counts toward that line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q <= 1'b0;
            line_wr <= 1'b0;
            row_cnt <= 2'd0;
        end else begin
            hsync_q <= hsync;
            if (line_end) begin
                line_wr <= 1'b0;
            end else if (pix_vld_d) begin
                line_wr <= 1'b1;
            end
            if (vsync) begin
                row_cnt <= 2'd0;
            end else if (line_end && (line_wr || pix_vld_d) && (row_cnt != 2'd2)) begin
                row_cnt <= 2'(row_cnt + 2'd1);
            end
        end
    end

endmodule

// File: tb/tb_median_window_gen.sv
// tb/tb_median_window_gen.sv - randomized and directed bench for median_window_gen against a line-level model
module tb_median_window_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsync = 1'b1;
    logic        vsync = 1'b0;
    logic [10:0] addr = '0;
    logic [7:0]  pix_in = '0;
    logic [71:0] win_out;
    logic        win_valid;

    median_window_gen #(.ADDR_W(11), .DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .hsync    (hsync),
        .vsync    (vsync),
        .addr     (addr),
        .pix_in   (pix_in),
        .win_out  (win_out),
        .win_valid(win_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [71:0] win;
        logic [23:0] row2;
    } exp_t;

    exp_t        exp_q[$];
    logic [71:0] obs_wins[$];
    int          n_assert = 0;
    int          n_fail = 0;

    // Reference state: whole lines of the current frame, the last three pixels shifted in
    logic [7:0]  prev1[64];
    logic [7:0]  prev2[64];
    logic [7:0]  cur[64];
    logic [7:0]  bot[3];
    int          ad[3];
    int          lines_done;
    int          run;
    logic        hs_prev;
    logic        line_has;

    task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic exp_t cur_exp(input logic vld);
        exp_t e;
        e.valid = vld;
        e.win   = '0;
        for (int c = 0; c < 3; c++) begin
            e.win[8*c       +: 8] = prev2[ad[c]];
            e.win[8*(3+c)   +: 8] = prev1[ad[c]];
            e.win[8*(6+c)   +: 8] = bot[c];
        end
        e.row2 = e.win[71:48];
        return e;
    endfunction

    task automatic model_in(input logic h, input logic v, input int a, input logic [7:0] p);
        logic vld;
        vld = 1'b0;
        if (!h) begin
            if (v) lines_done = 0;
            vld = (lines_done == 2) && (run >= 2);
            bot[0] = bot[1]; bot[1] = bot[2]; bot[2] = p;
            ad[0]  = ad[1];  ad[1]  = ad[2];  ad[2]  = a;
            cur[a] = p;
            line_has = 1'b1;
            run++;
        end else begin
            if (!hs_prev && line_has) begin
                for (int i = 0; i < 64; i++) begin
                    prev2[i] = prev1[i];
                    prev1[i] = cur[i];
                end
                if (lines_done < 2) lines_done++;
                line_has = 1'b0;
            end
            if (v) lines_done = 0;
            run = 0;
        end
        hs_prev = h;
        exp_q.push_back(cur_exp(vld));
    endtask

    task automatic cyc(input logic h, input logic v, input int a, input logic [7:0] p);
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL exp_queue observed=empty expected=entry");
        end else begin
            e = exp_q.pop_front();
            check_eq("win_valid", 72'(win_valid), 72'(e.valid));
            check_eq("row2", 72'(win_out[71:48]), 72'(e.row2));
            if (e.valid) check_eq("window", win_out, e.win);
        end
        if (win_valid === 1'b1) obs_wins.push_back(win_out);
        hsync  = h;
        vsync  = v;
        addr   = 11'(a);
        pix_in = p;
        model_in(h, v, a, p);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1; hsync = 1'b1; vsync = 1'b0; addr = '0; pix_in = '0;
        #1;
        check_eq("rst_win_out", win_out, 72'h0);
        check_eq("rst_win_valid", 72'(win_valid), 72'h0);
        for (int i = 0; i < 3; i++) begin
            bot[i] = '0;
            ad[i]  = 0;
        end
        lines_done = 0; run = 0; hs_prev = 1'b0; line_has = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(cur_exp(1'b0));
        model_in(1'b1, 1'b0, 0, 8'h00);
    endtask

    task automatic send_line(input int len, input int base, input bit rnd, input int ff_col);
        logic [7:0] p;
        for (int c = 0; c < len; c++) begin
            p = rnd ? 8'($urandom_range(0, 255)) : 8'(base + c);
            if (c == ff_col) p = 8'hFF;
            cyc(1'b0, 1'b0, c, p);
        end
    endtask

    task automatic blank(input int n, input logic v);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, (i == 0) ? v : 1'b0, 0, 8'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            prev1[i] = '0; prev2[i] = '0; cur[i] = '0;
        end
        do_reset();
        blank(3, 1'b1);

        send_line(8, 8'h00, 1'b0, -1); blank(4, 1'b0);
        send_line(8, 8'h10, 1'b0, -1); blank(4, 1'b0);
        obs_wins.delete();
        send_line(8, 8'h20, 1'b0, -1); blank(4, 1'b0);
        check_eq("line2_valid_count", 72'(obs_wins.size()), 72'd6);
        check_eq("line2_first_window", (obs_wins.size() > 0) ? obs_wins[0] : 72'hx,
                 72'h22_21_20_12_11_10_02_01_00);

        obs_wins.delete();
        send_line(8, 8'h30, 1'b0, -1); blank(4, 1'b0);
        check_eq("line3_first_window", (obs_wins.size() > 0) ? obs_wins[0] : 72'hx,
                 72'h32_31_30_22_21_20_12_11_10);

        obs_wins.delete();
        send_line(8, 0, 1'b1, 5); blank(4, 1'b1);
        check_eq("line4_valid_count", 72'(obs_wins.size()), 72'd6);

        obs_wins.delete();
        send_line(8, 0, 1'b1, -1); blank(4, 1'b0);
        send_line(8, 0, 1'b1, -1); blank(4, 1'b0);
        check_eq("after_vsync_valid_count", 72'(obs_wins.size()), 72'd0);
        send_line(8, 0, 1'b1, -1); blank(4, 1'b0);
        check_eq("new_frame_valid_count", 72'(obs_wins.size()), 72'd6);

        obs_wins.delete();
        send_line(8, 0, 1'b1, -1); blank(1, 1'b0);
        send_line(8, 0, 1'b1, -1); blank(20, 1'b0);
        check_eq("short_long_blank_count", 72'(obs_wins.size()), 72'd12);

        repeat (6) begin
            send_line(8, 0, 1'b1, -1);
            blank($urandom_range(1, 6), ($urandom_range(0, 3) == 0));
        end

        blank(3, 1'b1);
        repeat (3) begin
            send_line(16, 0, 1'b1, -1); blank(4, 1'b0);
        end
        send_line(10, 0, 1'b1, -1);
        do_reset();

        obs_wins.delete();
        send_line(16, 0, 1'b1, -1); blank(4, 1'b0);
        send_line(16, 0, 1'b1, -1); blank(4, 1'b0);
        check_eq("post_reset_two_lines", 72'(obs_wins.size()), 72'd0);
        send_line(16, 0, 1'b1, -1); blank(4, 1'b0);
        check_eq("post_reset_third_line", 72'(obs_wins.size()), 72'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/median_window_gen.md
Name: median_window_gen

Overview:
- Sits directly downstream of the line address counter. Takes the per-line pixel address and the incoming pixel stream, and stores the two previous lines in on-chip RAM.
- Each cycle it presents a 3x3 pixel neighbourhood to the median sorter.
- The address input is driven by the address counter, which clears on hsync and increments every clock. Pixel k of a line therefore arrives with addr = k.

Parameters:
- ADDR_W, 11, line RAM address width. Maximum line length is 2^ADDR_W pixels.
- DATA_W, 8, pixel width in bits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- hsync  input  1  line blanking, same signal that drives the address counter. High = no valid pixel.
- vsync  input  1  frame start, synchronous, active-high. Clears the row count.
- addr  input  ADDR_W  column address from the address counter.
- pix_in  input  DATA_W  pixel, valid in any cycle with hsync = 0.
- win_out  output  9*DATA_W  3x3 window. Element (r,c) is at [DATA_W*(3*r+c) +: DATA_W]. r=0 is the oldest line, c=0 the oldest column.
- win_valid  output  1  win_out holds a complete 3x3 window.

Behaviour:
- Storage: two simple-dual-port RAMs, line1 (previous line) and line2 (line before that). Each is 2^ADDR_W x DATA_W, with registered synchronous read and no reset of contents.
- Stage 0 (cycle t): read line1[addr] and line2[addr]. Register pix_in, addr and pix_vld = ~hsync into stage-1 registers.
- Stage 1 (cycle t+1):
  - Column triple is {top = line2 data, mid = line1 data, bot = pix_d}.
  - If pix_vld_d: write line1[addr_d] <= pix_d and line2[addr_d] <= line1 data (read-first value).
  - Write address addr_d never equals the concurrent read address (addr increments or jumps to 0), so no collision logic is needed.
- Stage 2 (edge at end of t+1): if pix_vld_d, shift the window left and load the triple into column 2. Otherwise the window holds.
- Latency: a pixel presented in cycle t is visible at win_out (r=2,c=2) in cycle t+2.
- col_cnt (2 bits):
  - Cleared when pix_vld_d = 0.
  - Incremented on each window shift, saturating at 3.
- row_cnt (2 bits):
  - Incremented on the rising edge of hsync (detected from a registered copy, hsync & ~hsync_q), and only if at least one pixel was written in the line just ended. Saturates at 2.
  - vsync = 1 forces row_cnt = 0 and takes priority over an increment in the same cycle.
- win_valid: registered, = (row_cnt == 2) && (col_cnt == 3 after the current shift) && shift occurred. It is therefore high with the third and later pixels of the third and later lines, and low in any cycle without a shift.
- Reset (asynchronous, any time, including mid-line):
  - Clears win_out to 0, win_valid to 0, col_cnt, row_cnt, hsync_q and all pipeline registers.
  - RAM contents are retained but treated as invalid: row_cnt = 0 guarantees no window using them is flagged valid.
- Pixels with addr ≥ 2^ADDR_W cannot occur; addr wrap-around is the address counter's responsibility.
- Line boundaries: col_cnt clears during blanking, so no window ever mixes the end of one line with the start of the next.

Test Plan:
- Reset mid-frame (rst pulse during line 3, pixel 10) -> win_out = 0 and win_valid = 0 immediately (asynchronous). After release, win_valid stays 0 until three complete lines have been received.
- Frame of 3 lines x 8 pixels, pix = 16*line + col, 4-cycle hsync between lines -> first win_valid on line 2, col 2. Window = {0x00,0x01,0x02, 0x10,0x11,0x12, 0x20,0x21,0x22}. Six valid windows on line 2.
- Latency check: single distinctive pixel 0xFF at line 2, col 5 -> appears at (2,2) exactly 2 cycles later, (2,1) at 3 cycles, (2,0) at 4 cycles.
- Line scrolling: fourth line (pix = 0x30+col) -> windows use lines 1,2,3; window at col 2 = {0x10,0x11,0x12, 0x20,0x21,0x22, 0x30,0x31,0x32}.
- vsync asserted together with an hsync rising edge after line 4 -> row_cnt = 0, no win_valid during the next two lines, valid again on the third line of the new frame.
- Blanking: hsync high for 1 cycle only, and separately for 20 cycles -> win_out holds during blanking and win_valid = 0. The next line restarts at col_cnt = 0 with no mixed-line windows.
